uart_tx_arbiter: RTL and testbench

//  Shares one UART transmitter among N_REQ requesters using round-robin arbitration.

---
 rtl/uart_tx_arbiter_if.sv | 25 ++
 rtl/uart_tx_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 351 +++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/uart_tx_arbiter_if.sv
// Handshake bundle between the requesters, the arbiter and the UART transmitter.
// The arbiter takes the master side; the requesters and transmitter take the slave side.
interface uart_tx_arbiter_if #(
   parameter int N_REQ  = 4,
   parameter int NBYTES = 2
);
   logic [N_REQ-1:0]          req;
   logic [N_REQ*8*NBYTES-1:0] req_data;
   logic [N_REQ-1:0]          gnt;
   logic [N_REQ-1:0]          pkt_done;
   logic                      busy;
   logic                      tx_trmt;
   logic [7:0]                tx_data;
   logic                      tx_done;

   modport master (
      input  req, req_data, tx_done,
      output gnt, pkt_done, busy, tx_trmt, tx_data
   );

   modport slave (
      output req, req_data, tx_done,
      input  gnt, pkt_done, busy, tx_trmt, tx_data
   );
endinterface

// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among N_REQ packet requesters.
// A winning packet is captured whole, then sent MSB byte first; each byte is
// started with a one-cycle tx_trmt and completed only by a rising tx_done.
module uart_tx_arbiter #(
   parameter int N_REQ  = 4,
   parameter int NBYTES = 2
) (
   input  logic               clk,
   input  logic               rst_n,
   uart_tx_arbiter_if.master  bus
);

   localparam int PKT_W = 8 * NBYTES;
   localparam int PW    = $clog2(N_REQ);
   localparam int CW    = $clog2(NBYTES) + 1;

   localparam logic [PW:0]      N_REQ_EXT = (PW+1)'(N_REQ);
   localparam logic [PW-1:0]    LAST_REQ  = PW'(N_REQ - 1);
   localparam logic [PW-1:0]    PTR_ONE   = PW'(1'b1);
   localparam logic [CW-1:0]    LAST_BYTE = CW'(NBYTES - 1);
   localparam logic [CW-1:0]    CNT_ONE   = CW'(1'b1);
   localparam logic [N_REQ-1:0] ONE_HOT0  = N_REQ'(1'b1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_WAIT = 2'd3
   } state_t;

   state_t            state_r;
   state_t            state_nxt_s;
   logic [PW-1:0]     ptr_r;
   logic [PW-1:0]     owner_r;
   logic [CW-1:0]     byte_cnt_r;
   logic [PKT_W-1:0]  pkt_buf_r;
   logic              tx_done_q_r;
   logic [N_REQ-1:0]  gnt_r;
   logic [N_REQ-1:0]  pkt_done_r;
   logic              busy_r;
   logic [7:0]        tx_data_r;

   logic [PW:0]       cand_s;
   logic              found_s;
   logic [PW-1:0]     win_idx_s;
   logic [PKT_W-1:0]  win_data_s;
   logic              done_rise_s;
   logic              last_byte_s;
   logic              capture_s;
   logic              load_s;
   logic              advance_s;
   logic              finish_s;

   // A byte completes only on a fresh rising edge of tx_done, never on a stale high level.
   assign done_rise_s = bus.tx_done & ~tx_done_q_r;
   assign last_byte_s = (byte_cnt_r == LAST_BYTE);

   // Round-robin search: first asserted request at or after ptr, wrapping modulo N_REQ.
   always_comb begin
      cand_s    = '0;
      found_s   = 1'b0;
      win_idx_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         cand_s = {1'b0, ptr_r} + (PW+1)'(i);
         cand_s = (cand_s >= N_REQ_EXT) ? (cand_s - N_REQ_EXT) : cand_s;
         if (!found_s && bus.req[cand_s[PW-1:0]]) begin
            found_s   = 1'b1;
            win_idx_s = cand_s[PW-1:0];
         end else begin
            found_s   = found_s;
            win_idx_s = win_idx_s;
         end
      end
   end

   // Select the winner's packet slice for capture.
   always_comb begin
      win_data_s = '0;
      for (int i = 0; i < N_REQ; i++) begin
         if (win_idx_s == PW'(i)) begin
            win_data_s = bus.req_data[i*PKT_W +: PKT_W];
         end else begin
            win_data_s = win_data_s;
         end
      end
   end

   // Next-state decode and datapath strobes for the packet sequencer.
   always_comb begin
      state_nxt_s = state_r;
      capture_s   = 1'b0;
      load_s      = 1'b0;
      advance_s   = 1'b0;
      finish_s    = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (|bus.req) begin
               capture_s   = 1'b1;
               state_nxt_s = ST_LOAD;
            end else begin
               state_nxt_s = ST_IDLE;
            end
         end
         ST_LOAD: begin
            load_s      = 1'b1;
            state_nxt_s = ST_SEND;
         end
         ST_SEND: begin
            state_nxt_s = ST_WAIT;
         end
         ST_WAIT: begin
            if (done_rise_s) begin
               if (last_byte_s) begin
                  finish_s    = 1'b1;
                  state_nxt_s = ST_IDLE;
               end else begin
                  advance_s   = 1'b1;
                  state_nxt_s = ST_LOAD;
               end
            end else begin
               state_nxt_s = ST_WAIT;
            end
         end
         default: begin
            state_nxt_s = ST_IDLE;
         end
      endcase
   end

   // Sequencer state register.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_IDLE;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Delayed copy of tx_done for rising-edge detection, sampled every cycle.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         tx_done_q_r <= 1'b0;
      end else begin
         tx_done_q_r <= bus.tx_done;
      end
   end

   // Packet buffer, owner, byte counter and round-robin pointer.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pkt_buf_r  <= '0;
         owner_r    <= '0;
         byte_cnt_r <= '0;
         ptr_r      <= '0;
      end else begin
         if (capture_s) begin
            pkt_buf_r  <= win_data_s;
            owner_r    <= win_idx_s;
            byte_cnt_r <= '0;
         end
         if (advance_s) begin
            pkt_buf_r  <= pkt_buf_r << 4'd8;
            byte_cnt_r <= byte_cnt_r + CNT_ONE;
         end
         if (finish_s) begin
            ptr_r <= (owner_r == LAST_REQ) ? '0 : (owner_r + PTR_ONE);
         end
      end
   end

   // Registered outputs: grant/done pulses, busy flag and the byte presented to the transmitter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         gnt_r      <= '0;
         pkt_done_r <= '0;
         busy_r     <= 1'b0;
         tx_data_r  <= 8'h00;
      end else begin
         gnt_r      <= capture_s ? (ONE_HOT0 << win_idx_s) : '0;
         pkt_done_r <= finish_s  ? (ONE_HOT0 << owner_r)   : '0;
         if (capture_s) begin
            busy_r <= 1'b1;
         end else if (finish_s) begin
            busy_r <= 1'b0;
         end
         if (load_s) begin
            tx_data_r <= pkt_buf_r[PKT_W-1 -: 8];
         end
      end
   end

   assign bus.gnt      = gnt_r;
   assign bus.pkt_done = pkt_done_r;
   assign bus.busy     = busy_r;
   assign bus.tx_data  = tx_data_r;
   // Start strobe is a pure decode of the SEND state.
   assign bus.tx_trmt  = (state_r == ST_SEND);

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Self-checking bench for uart_tx_arbiter: a vector table, directed corner-case
// sequences, and a randomized run against a packet-level reference model.
module tb_uart_tx_arbiter;
   localparam int N  = 4;
   localparam int NB = 2;

   logic clk = 1'b0;
   logic rst_n;
   always #10 clk = ~clk;

   uart_tx_arbiter_if #(.N_REQ(N), .NBYTES(NB)) ifc ();

   uart_tx_arbiter #(.N_REQ(N), .NBYTES(NB)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (ifc)
   );

   int   n_checks = 0;
   int   n_fail   = 0;
   logic auto_tx;
   logic tx_done_auto;
   logic tx_done_man;
   int   tx_cnt;

   assign ifc.tx_done = auto_tx ? tx_done_auto : tx_done_man;

   typedef struct {
      logic [3:0]  req;
      logic [63:0] data;
      logic [3:0]  exp_gnt;
      logic [15:0] exp_pkt;
   } vec_t;

   vec_t tbl [6];

   // Transmitter model: on a start strobe, drop tx_done and raise it again after a random time.
   initial begin
      tx_done_auto = 1'b1;
      tx_cnt = 0;
      forever begin
         @(negedge clk);
         if (auto_tx) begin
            if (tx_cnt > 0) begin
               tx_cnt--;
               if (tx_cnt == 0) tx_done_auto = 1'b1;
            end
            if (ifc.tx_trmt === 1'b1) begin
               tx_done_auto = 1'b0;
               tx_cnt = $urandom_range(1, 6);
            end
         end
      end
   end

   // Global time bound.
   initial begin
      #2ms;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1);
   end

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic wait_gnt(output logic [3:0] g, output int cyc);
      g = 4'b0000;
      cyc = -1;
      for (int k = 0; k < 40; k++) begin
         @(negedge clk);
         if (ifc.gnt !== 4'b0000) begin
            g = ifc.gnt;
            cyc = k + 1;
            break;
         end
      end
   endtask

   task automatic wait_trmt(output logic [7:0] d, output int cyc);
      d = 8'bx;
      cyc = -1;
      for (int k = 0; k < 60; k++) begin
         @(negedge clk);
         if (ifc.tx_trmt === 1'b1) begin
            d = ifc.tx_data;
            cyc = k + 1;
            break;
         end
      end
   endtask

   task automatic wait_pd(output logic [3:0] p, output int extra_gnt);
      p = 4'b0000;
      extra_gnt = 0;
      for (int k = 0; k < 100; k++) begin
         @(negedge clk);
         if (ifc.gnt !== 4'b0000) extra_gnt++;
         if (ifc.pkt_done !== 4'b0000) begin
            p = ifc.pkt_done;
            break;
         end
      end
   endtask

   task automatic do_reset();
      ifc.req = '0;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
   endtask

   function automatic int rr_pick(input logic [3:0] r, input int p);
      int w;
      w = -1;
      for (int k = 0; k < N; k++) begin
         if (w < 0 && r[(p + k) % N]) w = (p + k) % N;
      end
      return w;
   endfunction

   initial begin
      logic [3:0]  g;
      logic [3:0]  p;
      logic [7:0]  d;
      int          cyc;
      int          xg;
      int          cnt;
      int          ord [5];
      logic [3:0]  req_v;
      logic [63:0] data_v;
      logic [3:0]  req_seen;
      logic [63:0] data_seen;
      logic [7:0]  bq [$];
      logic [7:0]  eb;
      int          ptr_m;
      int          owner_m;
      int          w;
      bit          idle_m;
      bit          exp_next;
      bit          allow;

      rst_n = 1'b0;
      auto_tx = 1'b1;
      tx_done_man = 1'b1;
      ifc.req = '0;
      ifc.req_data = '0;

      tbl[0] = '{4'b0100, 64'h1111_A55A_2222_3333, 4'b0100, 16'hA55A};
      tbl[1] = '{4'b1111, 64'hC1C2_B1B2_A1A2_9192, 4'b1000, 16'hC1C2};
      tbl[2] = '{4'b0110, 64'h0102_0304_0506_0708, 4'b0010, 16'h0506};
      tbl[3] = '{4'b0011, 64'h1A2B_3C4D_5E6F_7081, 4'b0001, 16'h7081};
      tbl[4] = '{4'b1001, 64'hFEDC_BA98_7654_3210, 4'b1000, 16'hFEDC};
      tbl[5] = '{4'b1110, 64'h8001_4002_2004_1008, 4'b0010, 16'h2004};

      // Reset state.
      repeat (3) @(negedge clk);
      check("rst_gnt", ifc.gnt, 4'b0000);
      check("rst_pkt_done", ifc.pkt_done, 4'b0000);
      check("rst_busy", ifc.busy, 1'b0);
      check("rst_tx_trmt", ifc.tx_trmt, 1'b0);
      check("rst_tx_data", ifc.tx_data, 8'h00);
      rst_n = 1'b1;
      @(negedge clk);

      // Vector table: round-robin winner, captured bytes (data scrambled after grant), completion.
      for (int e = 0; e < 6; e++) begin
         ifc.req = tbl[e].req;
         ifc.req_data = tbl[e].data;
         wait_gnt(g, cyc);
         check("tbl_gnt", g, tbl[e].exp_gnt);
         check("tbl_gnt_lat", cyc, 1);
         check("tbl_busy_high", ifc.busy, 1'b1);
         ifc.req = '0;
         ifc.req_data = ~tbl[e].data;
         wait_trmt(d, cyc);
         check("tbl_byte0", d, tbl[e].exp_pkt[15:8]);
         check("tbl_trmt_lat", cyc, 1);
         wait_trmt(d, cyc);
         check("tbl_byte1", d, tbl[e].exp_pkt[7:0]);
         wait_pd(p, xg);
         check("tbl_pkt_done", p, tbl[e].exp_gnt);
         check("tbl_busy_low", ifc.busy, 1'b0);
      end

      // All four requesting from ptr=0: service order 0,1,2,3,0.
      do_reset();
      ord = '{0, 1, 2, 3, 0};
      ifc.req = 4'b1111;
      ifc.req_data = 64'h3131_2121_1111_0101;
      for (int k = 0; k < 5; k++) begin
         wait_gnt(g, cyc);
         check("rr_gnt", g, 4'b0001 << ord[k]);
         if (k == 4) ifc.req = '0;
         wait_pd(p, xg);
         check("rr_pkt_done", p, 4'b0001 << ord[k]);
         check("rr_gnt_inside_pkt", xg, 0);
      end

      // Request arriving while busy waits; granted one cycle after return to IDLE.
      ifc.req = 4'b1000;
      wait_gnt(g, cyc);
      check("wait_gnt3", g, 4'b1000);
      ifc.req = 4'b0010;
      wait_pd(p, xg);
      check("wait_pd3", p, 4'b1000);
      check("wait_no_early_gnt", xg, 0);
      @(negedge clk);
      check("wait_gnt1_next", ifc.gnt, 4'b0010);
      ifc.req = '0;
      wait_pd(p, xg);
      check("wait_pd1", p, 4'b0010);

      // tx_done held high from reset: only a fresh rising edge completes a byte.
      auto_tx = 1'b0;
      tx_done_man = 1'b1;
      do_reset();
      ifc.req = 4'b0001;
      ifc.req_data = 64'h0000_0000_0000_BEEF;
      wait_gnt(g, cyc);
      check("stale_gnt", g, 4'b0001);
      ifc.req = '0;
      wait_trmt(d, cyc);
      check("stale_byte0", d, 8'hBE);
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (ifc.tx_trmt === 1'b1) cnt++;
      end
      check("stale_no_skip", cnt, 0);
      tx_done_man = 1'b0;
      repeat (2) @(negedge clk);
      tx_done_man = 1'b1;
      @(negedge clk);
      check("gap_trmt_early", ifc.tx_trmt, 1'b0);
      @(negedge clk);
      check("gap_trmt", ifc.tx_trmt, 1'b1);
      check("stale_byte1", ifc.tx_data, 8'hEF);
      cnt = 0;
      repeat (5) begin
         @(negedge clk);
         if (ifc.pkt_done !== 4'b0000) cnt++;
      end
      check("stale_no_done", cnt, 0);
      tx_done_man = 1'b0;
      @(negedge clk);
      tx_done_man = 1'b1;
      @(negedge clk);
      check("stale_pkt_done", ifc.pkt_done, 4'b0001);
      check("stale_busy_low", ifc.busy, 1'b0);
      auto_tx = 1'b1;

      // Reset during WAIT of the second byte: outputs clear at once, no pkt_done, ptr back to 0.
      ifc.req = 4'b0100;
      ifc.req_data = 64'h0000_C0DE_0000_0000;
      wait_gnt(g, cyc);
      check("mid_gnt", g, 4'b0100);
      ifc.req = '0;
      wait_trmt(d, cyc);
      wait_trmt(d, cyc);
      check("mid_byte1", d, 8'hDE);
      @(negedge clk);
      rst_n = 1'b0;
      #1;
      check("mid_rst_gnt", ifc.gnt, 4'b0000);
      check("mid_rst_pkt_done", ifc.pkt_done, 4'b0000);
      check("mid_rst_busy", ifc.busy, 1'b0);
      check("mid_rst_trmt", ifc.tx_trmt, 1'b0);
      check("mid_rst_tx_data", ifc.tx_data, 8'h00);
      @(negedge clk);
      rst_n = 1'b1;
      cnt = 0;
      repeat (10) begin
         @(negedge clk);
         if (ifc.pkt_done !== 4'b0000) cnt++;
      end
      check("mid_no_pkt_done", cnt, 0);
      ifc.req = 4'b1111;
      wait_gnt(g, cyc);
      check("mid_ptr_zero", g, 4'b0001);
      ifc.req = '0;
      wait_pd(p, xg);
      check("mid_after_pd", p, 4'b0001);

      // Randomized run against a packet-level reference model.
      do_reset();
      ptr_m = 0;
      owner_m = 0;
      idle_m = 1'b1;
      exp_next = 1'b0;
      req_v = '0;
      data_v = '0;
      req_seen = '0;
      data_seen = '0;
      for (int ci = 0; ci < 3200; ci++) begin
         allow = (ci < 3000);
         @(negedge clk);
         if (exp_next) begin
            w = rr_pick(req_seen, ptr_m);
            check("rnd_gnt", ifc.gnt, 4'b0001 << w);
            owner_m = w;
            idle_m = 1'b0;
            bq.push_back(data_seen[w*16+8 +: 8]);
            bq.push_back(data_seen[w*16 +: 8]);
            req_v[w] = 1'b0;
            data_v[w*16 +: 16] = 16'($urandom);
         end else begin
            check("rnd_no_gnt", ifc.gnt, 4'b0000);
         end
         if (ifc.tx_trmt === 1'b1) begin
            check("rnd_byte_expected", bq.size() > 0, 1'b1);
            if (bq.size() > 0) begin
               eb = bq.pop_front();
               check("rnd_byte", ifc.tx_data, eb);
            end
         end
         if (ifc.pkt_done !== 4'b0000) begin
            check("rnd_pkt_done", ifc.pkt_done, idle_m ? 4'b0000 : (4'b0001 << owner_m));
            check("rnd_all_bytes_sent", bq.size(), 0);
            ptr_m = (owner_m + 1) % N;
            idle_m = 1'b1;
         end
         check("rnd_busy", ifc.busy, !idle_m);
         for (int i = 0; i < N; i++) begin
            if (!req_v[i]) begin
               if (allow && $urandom_range(0, 7) == 0) begin
                  req_v[i] = 1'b1;
                  data_v[i*16 +: 16] = 16'($urandom);
               end
            end else if (!allow || $urandom_range(0, 99) == 0) begin
               req_v[i] = 1'b0;
            end
         end
         ifc.req = req_v;
         ifc.req_data = data_v;
         req_seen = req_v;
         data_seen = data_v;
         exp_next = idle_m && (req_v != 4'b0000);
      end
      check("rnd_drained_idle", idle_m, 1'b1);
      check("rnd_queue_empty", bq.size(), 0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
